// File: rtl/hit_manager_pkg.sv
// ----------------------------------------------------------------------------
// hit_manager_pkg
// Shared definitions for the player hit/lives manager:
//   - FSM state encoding (ALIVE, HIT, INVULN, DEAD)
//   - default parameter values for lives, debounce and invulnerability
//   - datapath widths (no arithmetic wider than 10 bits)
//   - knockback direction helper
// ----------------------------------------------------------------------------
package hit_manager_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_HIT    = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } hm_state_t;

    localparam int LIVES_INIT_DEF      = 3;
    localparam int DEBOUNCE_FRAMES_DEF = 2;
    localparam int INVULN_FRAMES_DEF   = 90;

    localparam int POS_W   = 10;
    localparam int TIMER_W = 10;
    localparam int LIVES_W = 3;
    localparam int DEB_W   = 3;

    // Knockback pushes the player away from the hazard: 1 = push right when
    // the player is at or to the right of the hazard (ties push right).
    function automatic logic knock_right(input logic [POS_W-1:0] fx,
                                         input logic [POS_W-1:0] sx);
        return (fx >= sx);
    endfunction

endpackage

// File: rtl/hit_manager_frame_timer.sv
// ----------------------------------------------------------------------------
// frame_timer
// Reusable frame down-counter for object blocks.
//   clk      : system clock
//   reset    : asynchronous active-high reset (count -> 0)
//   clear    : synchronous clear to 0 (highest priority)
//   load     : load count with load_val
//   load_val : value to load
//   tick     : decrement by one (frame pulse); holds at 0, never wraps
//   count    : current count
//   zero     : count == 0
//   one      : count == 1 (last frame before expiry)
// ----------------------------------------------------------------------------
module frame_timer
    import hit_manager_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
    assign one   = (count_q == W'(1));

endmodule

// File: rtl/hit_manager.sv
// ----------------------------------------------------------------------------
// hit_manager
// Player hit detection, lives bookkeeping, knockback and invulnerability.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   frame_tick : one-clk pulse per video frame; collision is sampled only here
//   collision  : player/hazard overlap flag
//   f_x, s_x   : player and hazard x positions (10 bit, unsigned)
//   restart    : one-clk new-game request, overrides every other event
//   hit        : one-clk pulse while in HIT
//   knock_dir  : knockback direction latched at hit (0 left, 1 right)
//   lives      : remaining lives
//   invuln     : high in HIT and INVULN
//   blink      : sprite-hide strobe, INVULN and timer bit 3 set
//   game_over  : high in DEAD
// All outputs come from flops or are decoded from the registered state.
// ----------------------------------------------------------------------------
module hit_manager
    import hit_manager_pkg::*;
#(
    parameter int LIVES_INIT      = LIVES_INIT_DEF,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
    parameter int INVULN_FRAMES   = INVULN_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               collision,
    input  logic [POS_W-1:0]   f_x,
    input  logic [POS_W-1:0]   s_x,
    input  logic               restart,
    output logic               hit,
    output logic               knock_dir,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln,
    output logic               blink,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [TIMER_W-1:0] TMR_LOAD  = TIMER_W'(INVULN_FRAMES);

    hm_state_t          state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic               knock_q, knock_d;

    logic               tmr_clear;
    logic               tmr_load;
    logic               tmr_tick;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_zero;
    logic               tmr_one;

    frame_timer #(
        .W(TIMER_W)
    ) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .tick     (tmr_tick),
        .count    (tmr_count),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        deb_d     = deb_q;
        knock_d   = knock_q;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;

        if (restart) begin
            // New game wins over any hit, expiry or tick in the same cycle;
            // knock_dir deliberately keeps its last value.
            state_d   = ST_ALIVE;
            lives_d   = LIVES_RST;
            deb_d     = '0;
            tmr_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_ALIVE: begin
                    if (frame_tick) begin
                        if (collision) begin
                            // At the last debounce frame the counter holds
                            // (saturates) and the hit is taken instead.
                            if (deb_q >= DEB_LAST) begin
                                state_d = ST_HIT;
                            end else begin
                                deb_d = deb_q + DEB_W'(1);
                            end
                        end else begin
                            deb_d = '0;
                        end
                    end
                end

                ST_HIT: begin
                    knock_d = knock_right(f_x, s_x);
                    deb_d   = '0;
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d   = '0;
                        state_d   = ST_DEAD;
                        tmr_clear = 1'b1;
                    end else begin
                        lives_d  = lives_q - LIVES_W'(1);
                        state_d  = ST_INVULN;
                        tmr_load = 1'b1;
                    end
                end

                ST_INVULN: begin
                    tmr_tick = frame_tick;
                    // The timer lands on 0 on the same edge we leave INVULN.
                    // An already-zero timer can only arise from a corrupted
                    // state; fall back to ALIVE rather than sticking.
                    if ((frame_tick && tmr_one) || tmr_zero) begin
                        state_d = ST_ALIVE;
                    end
                end

                ST_DEAD: begin
                    lives_d = '0;
                end

                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ALIVE;
            lives_q <= LIVES_RST;
            deb_q   <= '0;
            knock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            deb_q   <= deb_d;
            knock_q <= knock_d;
        end
    end

    assign hit       = (state_q == ST_HIT);
    assign invuln    = (state_q == ST_HIT) || (state_q == ST_INVULN);
    assign blink     = (state_q == ST_INVULN) && tmr_count[3];
    assign game_over = (state_q == ST_DEAD);
    assign lives     = lives_q;
    assign knock_dir = knock_q;

endmodule

// File: doc/hit_manager.md
HIT_MANAGER -- requirements
Module: hit_manager

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at reset and restart (range 1..7).
REQ-002 Parameter DEBOUNCE_FRAMES, default 2, consecutive colliding frames needed to register a hit (range 1..7).
REQ-003 Parameter INVULN_FRAMES, default 90, frames of invulnerability after a non-fatal hit (range 1..1023).
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-clk pulse per video frame; the only sampling point for collision.
REQ-007 collision  input  1  combinational overlap flag from the collision detector (player vs. hazard).
REQ-008 f_x  input  10  player x position.
REQ-009 s_x  input  10  hazard x position.
REQ-010 restart  input  1  one-clk pulse requesting a new game.
REQ-011 hit  output  1  one-clk pulse when a hit is registered.
REQ-012 knock_dir  output  1  knockback direction latched at hit: 0 = push left, 1 = push right.
REQ-013 lives  output  3  remaining lives.
REQ-014 invuln  output  1  high while invulnerable.
REQ-015 blink  output  1  sprite-hide strobe during invulnerability.
REQ-016 game_over  output  1  high while in DEAD.

Function
REQ-017 FSM states: ALIVE, HIT, INVULN, DEAD; state register reset value ALIVE.
REQ-018 ALIVE: on frame_tick with collision=1, debounce counter increments; on frame_tick with collision=0, it clears; no change on non-tick cycles.
REQ-019 ALIVE -> HIT on the clk edge at which frame_tick=1, collision=1 and debounce counter = DEBOUNCE_FRAMES-1; the counter saturates and never wraps.
REQ-020 HIT lasts exactly one clk: hit=1, lives decrements by 1, knock_dir <= (f_x >= s_x), f_x/s_x sampled that cycle, compared unsigned; equal values give 1.
REQ-021 HIT -> DEAD if the decremented lives = 0, else HIT -> INVULN with frame timer loaded to INVULN_FRAMES and debounce cleared.
REQ-022 INVULN: collision ignored; timer decrements on each frame_tick; on frame_tick with timer = 1, go to ALIVE with timer 0; the timer never wraps below 0.
REQ-023 invuln = 1 in states HIT and INVULN only.
REQ-024 blink = 1 in INVULN when timer bit 3 = 1; blink = 0 in all other states.
REQ-025 DEAD: game_over=1; collision and frame_tick ignored; lives held at 0.
REQ-026 restart has priority over all other events in every state: next state ALIVE, lives <= LIVES_INIT, timer and debounce <= 0, knock_dir unchanged.
REQ-027 A restart coinciding with a hit-qualifying frame_tick suppresses the hit: hit stays 0 and lives are reloaded.
REQ-028 hit is never asserted in consecutive cycles; at most one hit per INVULN_FRAMES+1 frames.
REQ-029 All outputs are registered, or decoded only from registered state; no combinational path from input to output.

Reset
REQ-030 On reset: state ALIVE, lives=LIVES_INIT, debounce=0, timer=0, knock_dir=0, hit=0, invuln=0, blink=0, game_over=0.
REQ-031 Assertion of reset mid-operation (any state, including HIT) takes effect immediately, without waiting for a clock edge.
REQ-032 Deassertion: the first frame_tick after reset release is sampled normally.

Structure
REQ-033 State encodings and default parameter values live in the shared game definitions include file (game_defs.vh), alongside the other object and game constants.
REQ-034 The frame down-counter (load, decrement on tick, zero flag) is one sub-module, frame_timer, reusable by other object blocks.
REQ-035 The module holds no arithmetic wider than 10 bits; the timer is 10 bits.

Verification
REQ-036 Defaults; collision=1 for 2 frame_ticks -> hit pulses one clk after the 2nd tick, lives 3->2, invuln=1.
REQ-037 Collision pattern 1,0,1,0 across ticks, DEBOUNCE_FRAMES=2 -> no hit, lives stay 3.
REQ-038 After hit with f_x=100, s_x=120 -> knock_dir=0; separate run with f_x=120, s_x=120 -> knock_dir=1.
REQ-039 Collision held high continuously -> hits spaced exactly 92 frames apart (2 debounce + 90 invuln), lives 3->2->1->0, then game_over=1 and no further hits.
REQ-040 In DEAD, assert restart simultaneously with frame_tick and collision=1 -> next cycle state ALIVE, lives=3, hit=0, game_over=0.
REQ-041 Assert reset asynchronously mid-INVULN (timer=40) -> outputs reach their REQ-030 values before the next clk edge.
